// File: rtl/vga_addr_pkg.sv
// Shared types for the VGA window address generator.
// Holds the frame state enum and the addressing-mode enum.
package vga_addr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_LINEAR = 1'b0,
    MODE_TILED  = 1'b1
  } mode_e;

endpackage

// File: rtl/axis_tile_counter.sv
// Per-axis local/tile counter with stride accumulators.
// Ports: clk, reset (sync, active-high), clr, inc; off_d = next
// loc*LOC_STRIDE + tile*TILE_STRIDE, built without multipliers.
module axis_tile_counter
  import vga_addr_pkg::*;
#(
  parameter int TILE_SZ     = 100,
  parameter int TILE_CNT    = 4,
  parameter int LOC_STRIDE  = 1,
  parameter int TILE_STRIDE = 10000,
  parameter int CNT_W       = 10,
  parameter int ACC_W       = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [ACC_W-1:0] off_d
);

  localparam logic [CNT_W-1:0] LOC_LAST  = CNT_W'(TILE_SZ - 1);
  localparam logic [CNT_W-1:0] TILE_LAST = CNT_W'(TILE_CNT - 1);
  localparam logic [ACC_W-1:0] LOC_STEP  = ACC_W'(LOC_STRIDE);
  localparam logic [ACC_W-1:0] TILE_STEP = ACC_W'(TILE_STRIDE);

  logic [CNT_W-1:0] loc_q, loc_d;
  logic [CNT_W-1:0] tile_q, tile_d;
  logic [ACC_W-1:0] loc_acc_q, loc_acc_d;
  logic [ACC_W-1:0] tile_acc_q, tile_acc_d;
  logic             loc_wrap;
  logic             tile_wrap;

  assign loc_wrap  = (loc_q == LOC_LAST);
  assign tile_wrap = (tile_q == TILE_LAST);

  always_comb begin
    loc_d      = loc_q;
    tile_d     = tile_q;
    loc_acc_d  = loc_acc_q;
    tile_acc_d = tile_acc_q;
    if (clr) begin
      loc_d      = '0;
      tile_d     = '0;
      loc_acc_d  = '0;
      tile_acc_d = '0;
    end else if (inc) begin
      if (loc_wrap) begin
        loc_d     = '0;
        loc_acc_d = '0;
        if (tile_wrap) begin
          tile_d     = '0;
          tile_acc_d = '0;
        end else begin
          tile_d     = tile_q + CNT_W'(1);
          tile_acc_d = tile_acc_q + TILE_STEP;
        end
      end else begin
        loc_d     = loc_q + CNT_W'(1);
        loc_acc_d = loc_acc_q + LOC_STEP;
      end
    end
  end

  // Offset of the pixel being addressed this cycle (uses next values
  // so the address is ready one cycle after the coordinate).
  assign off_d = loc_acc_d + tile_acc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      loc_q      <= '0;
      tile_q     <= '0;
      loc_acc_q  <= '0;
      tile_acc_q <= '0;
    end else begin
      loc_q      <= loc_d;
      tile_q     <= tile_d;
      loc_acc_q  <= loc_acc_d;
      tile_acc_q <= tile_acc_d;
    end
  end

endmodule

// File: rtl/tile_address_gen.sv
// Window address generator: linear or tiled ROM addresses per pixel.
// In: clk, reset, x, y, enable, mode. Out: addr_out, addr_valid, we, frame_done.
module tile_address_gen
  import vga_addr_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int COORD_W = 10,
  parameter int X0      = 120,
  parameter int Y0      = 40,
  parameter int TILE_W  = 100,
  parameter int TILE_H  = 100,
  parameter int TILES_X = 4,
  parameter int TILES_Y = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               enable,
  input  logic               mode,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               addr_valid,
  output logic               we,
  output logic               frame_done
);

  localparam int WIN_W  = TILES_X * TILE_W;
  localparam int WIN_H  = TILES_Y * TILE_H;
  localparam int TILE_A = TILE_W * TILE_H;

  localparam longint WIN_PIX = longint'(WIN_W) * longint'(WIN_H);
  localparam longint ADDR_SP = longint'(1) << ADDR_W;
  localparam longint COORD_SP = longint'(1) << COORD_W;

  if (WIN_PIX > ADDR_SP) begin : g_addr_chk
    $error("tile_address_gen: window does not fit in ADDR_W");
  end
  if (longint'(X0 + WIN_W) > COORD_SP ||
      longint'(Y0 + WIN_H) > COORD_SP) begin : g_coord_chk
    $error("tile_address_gen: window exceeds coordinate range");
  end

  localparam logic [COORD_W:0]   X_LO   = (COORD_W+1)'(X0);
  localparam logic [COORD_W:0]   X_HI   = (COORD_W+1)'(X0 + WIN_W);
  localparam logic [COORD_W:0]   Y_LO   = (COORD_W+1)'(Y0);
  localparam logic [COORD_W:0]   Y_HI   = (COORD_W+1)'(Y0 + WIN_H);
  localparam logic [COORD_W-1:0] X_ORG  = COORD_W'(X0);
  localparam logic [COORD_W-1:0] Y_ORG  = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(X0 + WIN_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(Y0 + WIN_H - 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [COORD_W-1:0] x_q;
  logic [ADDR_W-1:0] lin_q, lin_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic              done_q, done_d;

  logic [COORD_W:0]  xe, ye;
  logic              in_win, at_org, at_last, row_first;
  logic              step, start, adv, use_tiled;
  logic              x_clr, x_inc, y_inc;
  logic [ADDR_W-1:0] x_off, y_off, tile_addr;

  assign xe        = {1'b0, x};
  assign ye        = {1'b0, y};
  assign in_win    = (xe >= X_LO) && (xe < X_HI) &&
                     (ye >= Y_LO) && (ye < Y_HI);
  assign at_org    = (x == X_ORG) && (y == Y_ORG);
  assign at_last   = (x == X_LAST) && (y == Y_LAST);
  assign row_first = (x == X_ORG);
  assign step      = (x != x_q);

  assign start = enable && (state_q == ARMED) && step && at_org;
  assign adv   = enable && (state_q == ACTIVE) && step && in_win;

  // First window pixel of a row restarts x and advances y; the frame
  // origin clears both axes.
  assign x_clr = start || (adv && row_first);
  assign x_inc = adv && !row_first;
  assign y_inc = adv && row_first;

  axis_tile_counter #(
    .TILE_SZ    (TILE_W),
    .TILE_CNT   (TILES_X),
    .LOC_STRIDE (1),
    .TILE_STRIDE(TILE_A),
    .CNT_W      (COORD_W),
    .ACC_W      (ADDR_W)
  ) u_x_axis (
    .clk  (clk),
    .reset(reset),
    .clr  (x_clr),
    .inc  (x_inc),
    .off_d(x_off)
  );

  axis_tile_counter #(
    .TILE_SZ    (TILE_H),
    .TILE_CNT   (TILES_Y),
    .LOC_STRIDE (TILE_W),
    .TILE_STRIDE(TILES_X * TILE_A),
    .CNT_W      (COORD_W),
    .ACC_W      (ADDR_W)
  ) u_y_axis (
    .clk  (clk),
    .reset(reset),
    .clr  (start),
    .inc  (y_inc),
    .off_d(y_off)
  );

  assign tile_addr = x_off + y_off;
  assign use_tiled = start ? mode : (mode_q == MODE_TILED);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = ARMED;
      ARMED:   if (start) state_d = ACTIVE;
      ACTIVE:  if (adv && at_last) state_d = ARMED;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  always_comb begin
    mode_d = start ? mode_e'(mode) : mode_q;
    lin_d  = lin_q;
    if (start) lin_d = '0;
    else if (adv) lin_d = lin_q + ADDR_W'(1);
    addr_d = addr_q;
    if (start || adv) addr_d = use_tiled ? tile_addr : lin_d;
    valid_d = start || (enable && (state_q == ACTIVE) && in_win);
    we_d    = start || (enable && (state_q == ACTIVE));
    // we still high while ARMED means the last pixel just went out.
    done_d  = enable && we_q && (state_q == ARMED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_LINEAR;
      x_q     <= '0;
      lin_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x;
      lin_q   <= lin_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign addr_out   = addr_q;
  assign addr_valid = valid_q;
  assign we         = we_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_tile_address_gen.sv
// Randomised bench for tile_address_gen against an arithmetic model.
// Two instances: a non-square window and the 2x2 of 8x8 tiles at origin.
module tb_tile_address_gen;

  localparam int NF = 16;
  localparam int SW = 64;
  localparam int SH = 48;

  localparam int P_X0 [2] = '{12, 0};
  localparam int P_Y0 [2] = '{4, 0};
  localparam int P_TW [2] = '{6, 8};
  localparam int P_TH [2] = '{5, 8};
  localparam int P_TX [2] = '{3, 2};
  localparam int P_TY [2] = '{4, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, mode;
  logic [9:0] x, y;

  logic [17:0] a_addr;
  logic        a_valid, a_we, a_done;
  logic [7:0]  b_addr;
  logic        b_valid, b_we, b_done;

  tile_address_gen #(
    .ADDR_W(18), .COORD_W(10), .X0(12), .Y0(4),
    .TILE_W(6), .TILE_H(5), .TILES_X(3), .TILES_Y(4)
  ) u_a (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .enable(enable), .mode(mode),
    .addr_out(a_addr), .addr_valid(a_valid),
    .we(a_we), .frame_done(a_done)
  );

  tile_address_gen #(
    .ADDR_W(8), .COORD_W(10), .X0(0), .Y0(0),
    .TILE_W(8), .TILE_H(8), .TILES_X(2), .TILES_Y(2)
  ) u_b (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .enable(enable), .mode(mode),
    .addr_out(b_addr), .addr_valid(b_valid),
    .we(b_we), .frame_done(b_done)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cur_x, cur_y;

  // Model state: 0 idle, 1 waiting for origin, 2 inside a frame.
  int ph [2];
  int px [2];
  int m_lat [2];
  int e_addr [2];
  int e_val [2];
  int e_we [2];
  int e_done [2];
  int pend [2];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at (%0d,%0d)",
                  tag, got, exp, cur_x, cur_y);
  endtask

  function automatic int ref_addr(int i, int xx, int yy, int tiled);
    int xo, yo;
    xo = xx - P_X0[i];
    yo = yy - P_Y0[i];
    if (tiled != 0)
      return ((yo / P_TH[i]) * P_TX[i] + xo / P_TW[i]) * P_TW[i] * P_TH[i]
             + (yo % P_TH[i]) * P_TW[i] + xo % P_TW[i];
    return yo * P_TW[i] * P_TX[i] + xo;
  endfunction

  task automatic model_step(int i, int xi, int yi, bit en, bit md, bit rs);
    bit stp, inw, at_o, at_l;
    int ww, wh;
    ww = P_TW[i] * P_TX[i];
    wh = P_TH[i] * P_TY[i];
    if (rs) begin
      ph[i] = 0; px[i] = 0; m_lat[i] = 0; e_addr[i] = 0;
      e_val[i] = 0; e_we[i] = 0; e_done[i] = 0; pend[i] = 0;
    end else begin
      stp = (xi != px[i]);
      px[i] = xi;
      inw = xi >= P_X0[i] && xi < P_X0[i] + ww &&
            yi >= P_Y0[i] && yi < P_Y0[i] + wh;
      at_o = xi == P_X0[i] && yi == P_Y0[i];
      at_l = xi == P_X0[i] + ww - 1 && yi == P_Y0[i] + wh - 1;
      e_done[i] = (en && pend[i] != 0) ? 1 : 0;
      pend[i] = 0;
      e_val[i] = 0;
      e_we[i] = 0;
      if (!en) ph[i] = 0;
      else if (ph[i] == 0) ph[i] = 1;
      else if (ph[i] == 1) begin
        if (stp && at_o) begin
          ph[i] = 2;
          m_lat[i] = md;
          e_val[i] = 1;
          e_we[i] = 1;
          e_addr[i] = ref_addr(i, xi, yi, m_lat[i]);
        end
      end else begin
        e_we[i] = 1;
        if (inw) begin
          e_val[i] = 1;
          if (stp) begin
            e_addr[i] = ref_addr(i, xi, yi, m_lat[i]);
            if (at_l) begin
              ph[i] = 1;
              pend[i] = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic cyc(int xi, int yi, bit en, bit md, bit rs);
    x = 10'(xi);
    y = 10'(yi);
    enable = en;
    mode = md;
    reset = rs;
    cur_x = xi;
    cur_y = yi;
    model_step(0, xi, yi, en, md, rs);
    model_step(1, xi, yi, en, md, rs);
    @(posedge clk);
    #1;
    check("a_addr", 32'(a_addr), e_addr[0]);
    check("a_valid", 32'(a_valid), e_val[0]);
    check("a_we", 32'(a_we), e_we[0]);
    check("a_done", 32'(a_done), e_done[0]);
    check("b_addr", 32'(b_addr), e_addr[1]);
    check("b_valid", 32'(b_valid), e_val[1]);
    check("b_we", 32'(b_we), e_we[1]);
    check("b_done", 32'(b_done), e_done[1]);
    // Fixed corner values for the 8x8 tiles and the window's last pixel.
    if (e_val[1] != 0 && m_lat[1] != 0) begin
      if (xi == 8 && yi == 0) check("b_t_8_0", 32'(b_addr), 64);
      if (xi == 0 && yi == 8) check("b_t_0_8", 32'(b_addr), 128);
    end
    if (e_val[1] != 0 && xi == 15 && yi == 15)
      check("b_last", 32'(b_addr), 255);
    if (e_val[0] != 0 && xi == 29 && yi == 23)
      check("a_last", 32'(a_addr), 359);
  endtask

  initial begin
    int drop;
    int reps;
    bit en, md, rs;
    drop = 0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < NF; f++) begin
      for (int yy = 0; yy < SH; yy++) begin
        for (int xx = 0; xx < SW; xx++) begin
          en = 1'b1;
          rs = 1'b0;
          md = 1'b0;
          case (f)
            0: md = 1'b1;
            1: md = 1'b0;
            2: md = (yy >= 10);
            3: begin
              md = 1'b1;
              en = !(yy == 10 && xx >= 20 && xx < 23);
            end
            4: rs = (yy == 12 && xx == 25);
            default: begin
              md = 1'($urandom_range(1));
              if (drop > 0) begin
                en = 1'b0;
                drop--;
              end else if ($urandom_range(2999) == 0) begin
                drop = $urandom_range(5, 1);
              end
              rs = ($urandom_range(4999) == 0);
            end
          endcase
          reps = 1;
          if (f >= 5 && $urandom_range(39) == 0 &&
              !(xx == 29 && yy == 23) && !(xx == 15 && yy == 15))
            reps = 2;
          for (int r = 0; r < reps; r++) cyc(xx, yy, en, md, rs);
        end
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
